// File: rtl/fault_freeze_ctrl.sv
// Fault freeze/rollback controller: freezes on a detected fault, requests a checkpoint
// rollback, limits recoveries, and halts permanently. Optional macro: FREEZE_TIMEOUT_EN.
module fault_freeze_ctrl #(
  parameter int FREEZE_CYCLES  = 4,
  parameter int MAX_RETRY      = 3,
  parameter int CLEAR_CYCLES   = 16,
  parameter int TIMEOUT_CYCLES = 32,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fault_detect,
  input  logic             rollback_ack,
  output logic             freeze_en,
  output logic             rollback_req,
  output logic             halted,
  output logic [CNT_W-1:0] fault_count
);

  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int FW = (FREEZE_CYCLES > 1) ? $clog2(FREEZE_CYCLES) : 1;
  localparam int CW = $clog2(CLEAR_CYCLES + 1);

  localparam logic [RW-1:0] MAX_R       = RW'(MAX_RETRY);
  localparam logic [FW-1:0] FREEZE_LAST = FW'(FREEZE_CYCLES - 1);
  localparam logic [CW-1:0] CLEAR_C     = CW'(CLEAR_CYCLES);

  typedef enum logic [1:0] {S_RUN, S_FREEZE, S_ROLLBACK, S_HALT} state_t;

  state_t           state_q;
  logic             freeze_en_q;
  logic             rollback_req_q;
  logic             halted_q;
  logic [CNT_W-1:0] fault_count_q;
  logic [CNT_W-1:0] fault_count_d;
  logic [RW-1:0]    retry_cnt_q;
  logic [FW-1:0]    freeze_cnt_q;
  logic [CW-1:0]    clean_cnt_q;
  logic [CW-1:0]    clean_cnt_d;

`ifdef FREEZE_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] to_cnt_q;
`endif

  // Both counters hold at their ceiling rather than wrapping.
  assign fault_count_d = (fault_count_q == '1) ? fault_count_q : fault_count_q + 1'b1;
  assign clean_cnt_d   = (clean_cnt_q == CLEAR_C) ? clean_cnt_q : clean_cnt_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_RUN;
      freeze_en_q    <= 1'b0;
      rollback_req_q <= 1'b0;
      halted_q       <= 1'b0;
      fault_count_q  <= '0;
      retry_cnt_q    <= '0;
      freeze_cnt_q   <= '0;
      clean_cnt_q    <= '0;
`ifdef FREEZE_TIMEOUT_EN
      to_cnt_q       <= '0;
`endif
    end else begin
      case (state_q)
        S_RUN: begin
          if (fault_detect) begin
            fault_count_q <= fault_count_d;
            clean_cnt_q   <= '0;
            freeze_en_q   <= 1'b1;
            if (retry_cnt_q < MAX_R) begin
              state_q      <= S_FREEZE;
              freeze_cnt_q <= '0;
            end else begin
              state_q  <= S_HALT;
              halted_q <= 1'b1;
            end
          end else begin
            clean_cnt_q <= clean_cnt_d;
            if (clean_cnt_d == CLEAR_C) retry_cnt_q <= '0;
          end
        end
        S_FREEZE: begin
          if (freeze_cnt_q == FREEZE_LAST) begin
            state_q        <= S_ROLLBACK;
            rollback_req_q <= 1'b1;
`ifdef FREEZE_TIMEOUT_EN
            to_cnt_q       <= '0;
`endif
          end else begin
            freeze_cnt_q <= freeze_cnt_q + 1'b1;
          end
        end
        S_ROLLBACK: begin
          // An ack on the final timeout cycle still counts as a successful recovery.
          if (rollback_ack) begin
            state_q        <= S_RUN;
            freeze_en_q    <= 1'b0;
            rollback_req_q <= 1'b0;
            clean_cnt_q    <= '0;
            if (retry_cnt_q < MAX_R) retry_cnt_q <= retry_cnt_q + 1'b1;
          end
`ifdef FREEZE_TIMEOUT_EN
          else if (to_cnt_q == TO_LAST) begin
            state_q        <= S_HALT;
            rollback_req_q <= 1'b0;
            halted_q       <= 1'b1;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
`endif
        end
        S_HALT: begin
          state_q <= S_HALT;
        end
        default: begin
          state_q <= S_RUN;
        end
      endcase
    end
  end

  assign freeze_en    = freeze_en_q;
  assign rollback_req = rollback_req_q;
  assign halted       = halted_q;
  assign fault_count  = fault_count_q;

endmodule

// File: tb/tb_fault_freeze_ctrl.sv
// Scoreboard bench for fault_freeze_ctrl: a phase-level reference model pushes the
// expected outputs for every cycle, and an independent monitor pops and compares them.
module tb_fault_freeze_ctrl;

  localparam int FRZ    = 4;
  localparam int MAXR   = 3;
  localparam int CLR    = 16;
  localparam int TOUT   = 32;
  localparam int CW     = 4;
  localparam int FC_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fault_detect = 1'b0;
  logic          rollback_ack = 1'b0;
  logic          freeze_en;
  logic          rollback_req;
  logic          halted;
  logic [CW-1:0] fault_count;

  always #5 clk = ~clk;

  fault_freeze_ctrl #(
    .FREEZE_CYCLES (FRZ),
    .MAX_RETRY     (MAXR),
    .CLEAR_CYCLES  (CLR),
    .TIMEOUT_CYCLES(TOUT),
    .CNT_W         (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .fault_detect (fault_detect),
    .rollback_ack (rollback_ack),
    .freeze_en    (freeze_en),
    .rollback_req (rollback_req),
    .halted       (halted),
    .fault_count  (fault_count)
  );

  typedef struct {
    bit fe;
    bit rr;
    bit h;
    int fc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic void chk(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, expv, $time);
    end
  endfunction

  // Reference model: a phase plus how long it has lasted, a recovery tally,
  // a clean-run length and the accepted-fault total.
  typedef enum {M_RUN, M_FREEZE, M_ROLLBACK, M_HALT} mode_t;
  mode_t m_mode    = M_RUN;
  int    m_elapsed = 0;
  int    m_retries = 0;
  int    m_clean   = 0;
  int    m_faults  = 0;

  always @(posedge clk) begin
    exp_t e;
    if (rst) begin
      m_mode = M_RUN; m_elapsed = 0; m_retries = 0; m_clean = 0; m_faults = 0;
    end else begin
      case (m_mode)
        M_RUN: begin
          if (fault_detect) begin
            m_faults = (m_faults < FC_MAX) ? m_faults + 1 : FC_MAX;
            m_clean  = 0;
            if (m_retries < MAXR) begin
              m_mode = M_FREEZE; m_elapsed = 0;
            end else begin
              m_mode = M_HALT;
            end
            $display("txn: fault accepted total=%0d retries=%0d -> %s", m_faults, m_retries,
                     (m_mode == M_HALT) ? "halt" : "freeze");
          end else begin
            m_clean++;
            if (m_clean >= CLR) begin
              m_clean = CLR; m_retries = 0;
            end
          end
        end
        M_FREEZE: begin
          m_elapsed++;
          if (m_elapsed == FRZ) begin
            m_mode = M_ROLLBACK; m_elapsed = 0;
          end
        end
        M_ROLLBACK: begin
          if (rollback_ack) begin
            m_mode = M_RUN; m_retries++; m_clean = 0;
          end else begin
            m_elapsed++;
`ifdef FREEZE_TIMEOUT_EN
            if (m_elapsed == TOUT) m_mode = M_HALT;
`endif
          end
        end
        default: ;
      endcase
    end
    e.fe = (m_mode != M_RUN);
    e.rr = (m_mode == M_ROLLBACK);
    e.h  = (m_mode == M_HALT);
    e.fc = m_faults;
    sb.push_back(e);
  end

  // Monitor: every cycle the DUT presents a new output set, compared at the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("freeze_en", int'(freeze_en), int'(e.fe));
      chk("rollback_req", int'(rollback_req), int'(e.rr));
      chk("halted", int'(halted), int'(e.h));
      chk("fault_count", int'(fault_count), e.fc);
    end
  end

  task automatic cyc(input bit fd, input bit ack);
    @(negedge clk);
    #1;
    fault_detect = fd;
    rollback_ack = ack;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0);
  endtask

  task automatic recover_one();
    cyc(1'b1, 1'b0);
    idle(FRZ);
    cyc(1'b0, 1'b1);
  endtask

  // Reset asserted between clock edges; outputs must clear without waiting for clk.
  task automatic do_reset();
    @(negedge clk);
    #2;
    fault_detect = 1'b0;
    rollback_ack = 1'b0;
    rst = 1'b1;
    sb.delete();
    #1;
    chk("async_rst_freeze_en", int'(freeze_en), 0);
    chk("async_rst_rollback_req", int'(rollback_req), 0);
    chk("async_rst_halted", int'(halted), 0);
    chk("async_rst_fault_count", int'(fault_count), 0);
    @(negedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_freeze_en", int'(freeze_en), 0);
    chk("reset_rollback_req", int'(rollback_req), 0);
    chk("reset_halted", int'(halted), 0);
    chk("reset_fault_count", int'(fault_count), 0);
    #2;
    rst = 1'b0;
    idle(3);

    // Single fault, ack two cycles after rollback_req rises.
    cyc(1'b1, 1'b0);
    idle(FRZ + 2);
    cyc(1'b0, 1'b1);
    idle(20);
    chk("single_fault_count", int'(fault_count), 1);

    // Four closely spaced faults: three recoveries, then permanent halt.
    do_reset();
    repeat (4) begin
      recover_one();
      idle(2);
    end
    idle(3);
    chk("halt_after_4_halted", int'(halted), 1);
    chk("halt_after_4_freeze", int'(freeze_en), 1);
    chk("halt_after_4_count", int'(fault_count), 4);

    // Retry count cleared by a long clean run, so three more faults do not halt.
    do_reset();
    recover_one();
    idle(20);
    repeat (3) begin
      recover_one();
      idle(2);
    end
    chk("clear_no_halt", int'(halted), 0);

    // fault_detect held high through the whole sequence, including the return cycle.
    do_reset();
    repeat (FRZ + 1) cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b0);
    idle(FRZ);
    cyc(1'b0, 1'b1);
    idle(2);
    chk("held_fault_count", int'(fault_count), 2);

    // Reset mid-rollback, then a normal freeze afterwards.
    do_reset();
    cyc(1'b1, 1'b0);
    idle(FRZ + 2);
    do_reset();
    idle(2);
    recover_one();
    idle(3);

    // Rollback without any ack.
    do_reset();
    cyc(1'b1, 1'b0);
    idle(FRZ + 100);
`ifdef FREEZE_TIMEOUT_EN
    chk("no_ack_halted", int'(halted), 1);
`else
    chk("no_ack_still_requesting", int'(rollback_req), 1);
`endif

    // Saturation of fault_count with retries cleared between faults.
    do_reset();
    repeat (FC_MAX + 2) begin
      recover_one();
      idle(CLR + 1);
    end
    chk("fault_count_saturated", int'(fault_count), FC_MAX);

    // Randomized traffic with occasional resets, mostly to leave HALT.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      int fd_div;
      fd_div = (i < 2000) ? 8 : 30;
      if ((m_mode == M_HALT && $urandom_range(0, 19) == 0) || $urandom_range(0, 799) == 0)
        do_reset();
      else
        cyc($urandom_range(0, fd_div - 1) == 0, $urandom_range(0, 2) == 0);
    end
    idle(2);
    chk("scoreboard_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
